// File: rtl/frame_pkg.sv
// Shared constants and FSM state type for the frame read path and frame_fifo users.
package frame_pkg;

    localparam int DATA_W     = 256;
    localparam int FIFO_DEPTH = 256;
    localparam int MAX_BURST  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        DRAIN,
        FINISH
    } frc_state_t;

endpackage

// File: rtl/frame_read_ctrl.sv
// Issues Avalon-MM burst reads for one frame and streams the returned beats into frame_fifo,
// holding off each burst until the FIFO is guaranteed to have room for it.
module frame_read_ctrl #(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = frame_pkg::DATA_W,
    parameter int WORDS_W    = 20,
    parameter int MAX_BURST  = frame_pkg::MAX_BURST,
    parameter int BC_W       = 5,
    parameter int FIFO_DEPTH = frame_pkg::FIFO_DEPTH,
    parameter int USEDW_W    = 8,
    parameter int SLACK      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  frame_base_i,
    input  logic [WORDS_W-1:0] frame_words_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [ADDR_W-1:0]  avm_address_o,
    output logic               avm_read_o,
    output logic [BC_W-1:0]    avm_burstcount_o,
    input  logic               avm_waitrequest_i,
    input  logic               avm_readdatavalid_i,
    input  logic [DATA_W-1:0]  avm_readdata_i,
    output logic [DATA_W-1:0]  fifo_data_o,
    output logic               fifo_wrreq_o,
    input  logic [USEDW_W-1:0] fifo_wrusedw_i,
    input  logic               fifo_wrfull_i
);
    import frame_pkg::*;

    localparam int OUT_W = USEDW_W + 1;
    // Two extra bits so usedw + outstanding + burst can never wrap before the compare.
    localparam int SUM_W = USEDW_W + 2;
    localparam logic [SUM_W-1:0] LIMIT = SUM_W'(FIFO_DEPTH - SLACK);

    frc_state_t         state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORDS_W-1:0] remain_q;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [BC_W-1:0]    bc_q;
    logic               rd_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               wr_q;
    logic [DATA_W-1:0]  data_q;

    logic [BC_W-1:0]    burst;
    logic [SUM_W-1:0]   need;
    logic               fits;
    logic               accept;
    logic               beat_ok;
    logic               err_evt;

    always_comb begin
        burst = (remain_q >= WORDS_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : remain_q[BC_W-1:0];
        need  = SUM_W'(fifo_wrusedw_i) + SUM_W'(outstanding_q) + SUM_W'(burst);
        fits  = (need <= LIMIT);
        accept  = rd_q && !avm_waitrequest_i;
        // A beat with nothing outstanding is unsolicited; it is dropped, not written.
        beat_ok = avm_readdatavalid_i && (outstanding_q != '0);
        err_evt = (avm_readdatavalid_i && (outstanding_q == '0)) || (wr_q && fifo_wrfull_i);
        outstanding_d = outstanding_q
                      + (accept  ? OUT_W'(bc_q) : '0)
                      - (beat_ok ? OUT_W'(1)    : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q          <= 1'b0;
            data_q        <= '0;
            outstanding_q <= '0;
        end else begin
            wr_q          <= beat_ok;
            data_q        <= avm_readdata_i;
            outstanding_q <= outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            bc_q     <= '0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (err_evt) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q   <= frame_base_i;
                        remain_q <= frame_words_i;
                        busy_q   <= 1'b1;
                        err_q    <= err_evt;
                        state_q  <= (frame_words_i == '0) ? FINISH : CHECK;
                    end
                end
                CHECK: begin
                    if (fits) begin
                        rd_q    <= 1'b1;
                        bc_q    <= burst;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!avm_waitrequest_i) begin
                        rd_q     <= 1'b0;
                        addr_q   <= addr_q + ADDR_W'(bc_q);
                        remain_q <= remain_q - WORDS_W'(bc_q);
                        state_q  <= (remain_q == WORDS_W'(bc_q)) ? DRAIN : CHECK;
                    end
                end
                DRAIN: begin
                    // The last beat still sits in the output register for one cycle.
                    if ((outstanding_q == '0) && !wr_q) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign avm_address_o    = addr_q;
    assign avm_read_o       = rd_q;
    assign avm_burstcount_o = bc_q;
    assign fifo_data_o      = data_q;
    assign fifo_wrreq_o     = wr_q;

endmodule
